// File: rtl/core_pkg.sv
// Shared core definitions: major opcodes and the
// vector element sequencer state encoding.
package core_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_VECTOR = 7'b1010111;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } vseq_state_e;

endpackage

// File: rtl/vec_seq_ctrl.sv
// Vector element sequencer: accepts a vector op, stalls the front end,
// issues one element per cycle to the ALU and writes results back.
//   clk_i/rst_ni        clock, async active-low reset
//   issue_valid_i       decode presents an instruction
//   opcode_i/vl_i       opcode and requested element count
//   flush_i             pipeline kill
//   issue_ready_o       idle, can accept
//   stall_o             hold fetch/decode
//   elem_valid_o/idx_o  element issue to ALU
//   vrf_we_o/widx_o     element writeback, one cycle after issue
//   done_o              completion pulse
module vec_seq_ctrl
  import core_pkg::*;
#(
  parameter int VLMAX = 8,
  parameter int IDX_W = $clog2(VLMAX)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             issue_valid_i,
  input  logic [6:0]       opcode_i,
  input  logic [IDX_W:0]   vl_i,
  input  logic             flush_i,
  output logic             issue_ready_o,
  output logic             stall_o,
  output logic             elem_valid_o,
  output logic [IDX_W-1:0] elem_idx_o,
  output logic             vrf_we_o,
  output logic [IDX_W-1:0] vrf_widx_o,
  output logic             done_o
);

  localparam logic [IDX_W:0] VLMAX_L = (IDX_W+1)'(VLMAX);
  localparam logic [IDX_W:0] ONE_L   = (IDX_W+1)'(1);
  localparam logic [IDX_W-1:0] INC_L = IDX_W'(1);

  vseq_state_e      state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic [IDX_W:0]   vl_q, vl_d;
  logic             we_q, we_d;
  logic [IDX_W-1:0] widx_q, widx_d;
  logic [IDX_W:0]   vl_eff;
  logic             accept;
  logic             last;

  assign vl_eff = (vl_i > VLMAX_L) ? VLMAX_L : vl_i;
  assign accept = issue_valid_i && (opcode_i == OPC_VECTOR) && !flush_i;
  // Counter stops at the terminal index, so it never wraps.
  assign last   = ({1'b0, cnt_q} == (vl_q - ONE_L));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    vl_d    = vl_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          vl_d    = vl_eff;
          cnt_d   = '0;
          state_d = (vl_eff == '0) ? DRAIN : RUN;
        end
      end
      RUN: begin
        if (flush_i) begin
          state_d = IDLE;
        end else if (last) begin
          state_d = DRAIN;
        end else begin
          cnt_d = cnt_q + INC_L;
        end
      end
      DRAIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // A flushed element's write is dropped on its way to writeback.
  assign we_d   = (state_q == RUN) && !flush_i;
  assign widx_d = cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      vl_q    <= '0;
      we_q    <= 1'b0;
      widx_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      vl_q    <= vl_d;
      we_q    <= we_d;
      widx_q  <= widx_d;
    end
  end

  assign issue_ready_o = (state_q == IDLE);
  assign stall_o       = (state_q != IDLE);
  assign elem_valid_o  = (state_q == RUN);
  assign elem_idx_o    = (state_q == RUN) ? cnt_q : '0;
  assign done_o        = (state_q == DRAIN);
  assign vrf_we_o      = we_q;
  assign vrf_widx_o    = we_q ? widx_q : '0;

endmodule

// File: tb/tb_vec_seq_ctrl.sv
// Directed self-checking bench for vec_seq_ctrl.
module tb_vec_seq_ctrl;

  localparam int VLMAX = 8;
  localparam int IDX_W = 3;

  logic             clk_i = 1'b0;
  logic             rst_ni;
  logic             issue_valid_i;
  logic [6:0]       opcode_i;
  logic [IDX_W:0]   vl_i;
  logic             flush_i;
  logic             issue_ready_o;
  logic             stall_o;
  logic             elem_valid_o;
  logic [IDX_W-1:0] elem_idx_o;
  logic             vrf_we_o;
  logic [IDX_W-1:0] vrf_widx_o;
  logic             done_o;

  int n_cmp = 0;
  int n_bad = 0;

  vec_seq_ctrl #(.VLMAX(VLMAX), .IDX_W(IDX_W)) dut (
    .clk_i(clk_i),
    .rst_ni(rst_ni),
    .issue_valid_i(issue_valid_i),
    .opcode_i(opcode_i),
    .vl_i(vl_i),
    .flush_i(flush_i),
    .issue_ready_o(issue_ready_o),
    .stall_o(stall_o),
    .elem_valid_o(elem_valid_o),
    .elem_idx_o(elem_idx_o),
    .vrf_we_o(vrf_we_o),
    .vrf_widx_o(vrf_widx_o),
    .done_o(done_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".ready"}, 32'(issue_ready_o), 1);
    chk({tag, ".stall"}, 32'(stall_o), 0);
    chk({tag, ".ev"}, 32'(elem_valid_o), 0);
    chk({tag, ".we"}, 32'(vrf_we_o), 0);
    chk({tag, ".done"}, 32'(done_o), 0);
  endtask

  // Checks cycles 1..vle+1 after an accept; leaves bench in cycle vle+2.
  task automatic check_run(input string tag, input int vle);
    int nw;
    nw = 0;
    for (int c = 1; c <= vle + 1; c++) begin
      chk({tag, ".ev"}, 32'(elem_valid_o), 32'(c <= vle));
      if (c <= vle) chk({tag, ".idx"}, 32'(elem_idx_o), 32'(c - 1));
      chk({tag, ".we"}, 32'(vrf_we_o), 32'(c >= 2));
      if (c >= 2) chk({tag, ".widx"}, 32'(vrf_widx_o), 32'(c - 2));
      chk({tag, ".done"}, 32'(done_o), 32'(c == vle + 1));
      chk({tag, ".stall"}, 32'(stall_o), 1);
      chk({tag, ".ready"}, 32'(issue_ready_o), 0);
      if (vrf_we_o) nw++;
      step();
    end
    chk({tag, ".nwrites"}, 32'(nw), 32'(vle));
  endtask

  task automatic issue(input logic [6:0] opc, input int vl);
    issue_valid_i = 1'b1;
    opcode_i      = opc;
    vl_i          = (IDX_W+1)'(vl);
    step();
    issue_valid_i = 1'b0;
  endtask

  initial begin
    int nd;
    rst_ni        = 1'b0;
    issue_valid_i = 1'b0;
    opcode_i      = '0;
    vl_i          = '0;
    flush_i       = 1'b0;
    #1;
    chk_idle("reset");
    #20;
    @(negedge clk_i);
    rst_ni = 1'b1;
    step();
    chk_idle("post_reset");

    issue(7'b1010111, 4);
    check_run("vl4", 4);
    chk_idle("vl4.after");

    issue(7'b1010111, 12);
    check_run("vl12", 8);
    chk_idle("vl12.after");

    issue(7'b1010111, 0);
    check_run("vl0", 0);
    chk_idle("vl0.after");

    issue_valid_i = 1'b1;
    opcode_i      = 7'b0110011;
    vl_i          = 4'd4;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_idle("nonvec");
    end
    issue_valid_i = 1'b0;

    issue(7'b1010111, 6);
    chk("fl.c1.ev", 32'(elem_valid_o), 1);
    step();
    chk("fl.c2.ev", 32'(elem_valid_o), 1);
    chk("fl.c2.we", 32'(vrf_we_o), 1);
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    chk_idle("fl.c3");
    nd = 0;
    for (int i = 0; i < 8; i++) begin
      if (done_o || vrf_we_o) nd++;
      step();
    end
    chk("fl.no_done", 32'(nd), 0);

    issue(7'b1010111, 6);
    step();
    #2;
    rst_ni = 1'b0;
    #1;
    chk_idle("arst");
    @(negedge clk_i);
    rst_ni = 1'b1;
    step();
    chk_idle("arst.after");
    issue(7'b1010111, 2);
    check_run("arst.vl2", 2);
    chk_idle("arst.vl2.after");

    issue_valid_i = 1'b1;
    opcode_i      = 7'b1010111;
    vl_i          = 4'd3;
    step();
    vl_i = 4'd2;
    check_run("b2b.first", 3);
    chk_idle("b2b.gap");
    step();
    issue_valid_i = 1'b0;
    check_run("b2b.second", 2);
    chk_idle("b2b.after");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
